modulation_memory: RTL

- Responder side of the modulation bus. Stores two modulation segments and returns an 8-bit modulation value for each (segment, index) request from the modulation multiplier.
- Fixed 2-cycle read latency, matching the multiplier's two load-wait states.
- Host CPU bus writes segment contents, 16 bits per word.
- After reset, an internal clear sequencer zeroes both segments before the block reports ready.

---
 rtl/modulation_pkg.sv | 13 +
 rtl/mod_bank_ram.sv | 45 ++++
 rtl/modulation_memory.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/modulation_pkg.sv
// Shared definitions for the modulation memory responder: default depth,
// read latency and the clear/ready state encoding.
package modulation_pkg;

    localparam int ModDepthLog2   = 15;
    localparam int ModReadLatency = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/mod_bank_ram.sv
// One 8-bit simple dual-port bank: synchronous write with a clear-write
// override, registered read-first output.
module mod_bank_ram
    import modulation_pkg::*;
#(
    parameter int AW = ModDepthLog2 - 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0]    mem [2**AW];
    logic          wen_d;
    logic [AW-1:0] waddr_d;
    logic [7:0]    wdata_d;
    logic [7:0]    rdata_q;

    always_comb begin
        wen_d   = we;
        waddr_d = waddr;
        wdata_d = wdata;
        if (clr_en) begin
            wen_d   = 1'b1;
            waddr_d = clr_addr;
            wdata_d = '0;
        end
    end

    // Nonblocking write and read on the same edge give old data on a collision.
    always_ff @(posedge clk) begin
        if (wen_d) begin
            mem[waddr_d] <= wdata_d;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/modulation_memory.sv
// Modulation bus responder: two segments, fixed 2-cycle read latency, CPU word
// writes, clear-after-reset. Define MODULATION_MEMORY_OOR_COUNT_EN to add OOR_COUNT.
module modulation_memory
    import modulation_pkg::*;
#(
    parameter int DEPTH_LOG2     = ModDepthLog2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [14:0] IDX,
    input  logic        SEGMENT,
    output logic [7:0]  VALUE,
    input  logic [14:0] CYCLE_0,
    input  logic [14:0] CYCLE_1,
    input  logic        CPU_WE,
    input  logic        CPU_SEGMENT,
    input  logic [13:0] CPU_ADDR,
    input  logic [15:0] CPU_DATA,
    output logic        READY,
    output logic        OOR_ERR,
    input  logic        OOR_CLR
`ifdef MODULATION_MEMORY_OOR_COUNT_EN
    ,
    output logic [15:0] OOR_COUNT
`endif
);

    localparam int            AW       = DEPTH_LOG2 - 1;
    localparam logic [AW-1:0] ClrLast  = '1;
    localparam state_t        RstState = (CLEAR_ON_RESET != 0) ? modulation_pkg::CLEAR
                                                               : modulation_pkg::READY;

    state_t                state_q, state_d;
    logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  seg_q, seg_d;
    logic                  valid1_q, valid1_d;
    logic                  oor_q, oor_d;
    logic                  odd2_q, odd2_d;
    logic                  seg2_q, seg2_d;
    logic                  valid2_q, valid2_d;
    logic                  err_q, err_d;
    logic                  wr_en_q, wr_en_d;
    logic                  wr_seg_q, wr_seg_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic                  ready;
    logic                  clearing;
    logic [7:0]            bank_rdata [2][2];
    logic [7:0]            value;

    assign ready    = (state_q == modulation_pkg::READY);
    assign clearing = (state_q == modulation_pkg::CLEAR);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            modulation_pkg::CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ClrLast) begin
                    state_d   = modulation_pkg::READY;
                    clr_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Reads are suppressed to zero while clearing or out of range; the CPU
    // write is staged one cycle so a same-cycle read still sees old data.
    always_comb begin
        oor_d     = IDX > (SEGMENT ? CYCLE_1 : CYCLE_0);
        idx_d     = IDX[DEPTH_LOG2-1:0];
        seg_d     = SEGMENT;
        valid1_d  = ready & ~oor_d;
        odd2_d    = idx_q[0];
        seg2_d    = seg_q;
        valid2_d  = valid1_q;
        err_d     = OOR_CLR ? 1'b0 : (err_q | oor_q);
        wr_en_d   = CPU_WE & ready;
        wr_seg_d  = CPU_SEGMENT;
        wr_addr_d = CPU_ADDR[AW-1:0];
        wr_data_d = CPU_DATA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= RstState;
            clr_cnt_q <= '0;
            idx_q     <= '0;
            seg_q     <= 1'b0;
            valid1_q  <= 1'b0;
            oor_q     <= 1'b0;
            odd2_q    <= 1'b0;
            seg2_q    <= 1'b0;
            valid2_q  <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_seg_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            valid1_q  <= valid1_d;
            oor_q     <= oor_d;
            odd2_q    <= odd2_d;
            seg2_q    <= seg2_d;
            valid2_q  <= valid2_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_seg_q  <= wr_seg_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_seg
        for (genvar b = 0; b < 2; b++) begin : g_bank
            mod_bank_ram #(
                .AW(AW)
            ) u_ram (
                .clk      (CLK),
                .we       (wr_en_q && (wr_seg_q == 1'(s))),
                .waddr    (wr_addr_q),
                .wdata    (wr_data_q[8*b +: 8]),
                .clr_en   (clearing),
                .clr_addr (clr_cnt_q),
                .raddr    (idx_q[DEPTH_LOG2-1:1]),
                .rdata    (bank_rdata[s][b])
            );
        end
    end

    always_comb begin
        value = '0;
        if (valid2_q) begin
            value = bank_rdata[seg2_q][odd2_q];
        end
    end

    assign VALUE   = value;
    assign READY   = ready;
    assign OOR_ERR = err_q;

`ifdef MODULATION_MEMORY_OOR_COUNT_EN
    logic [15:0] oor_cnt_q, oor_cnt_d;

    always_comb begin
        oor_cnt_d = oor_cnt_q;
        if (OOR_CLR) begin
            oor_cnt_d = '0;
        end else if (oor_q && (oor_cnt_q != '1)) begin
            oor_cnt_d = oor_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            oor_cnt_q <= '0;
        end else begin
            oor_cnt_q <= oor_cnt_d;
        end
    end

    assign OOR_COUNT = oor_cnt_q;
`endif

endmodule
